// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers and mode encodings for the converter family.
// Functions work on 32-bit zero-extended words, so any WIDTH up to 32 narrows cleanly.
package gray_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;
  localparam int   MAX_W    = 32;

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [5:0] popcount(input logic [MAX_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Gray step monitor: flags accepted G2B words that move more than one bit from the last one.
// Flag is combinational with the accept; history and saturating count update on the same edge.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_chk,
  input  logic                 i_clr,
  input  logic [WIDTH-1:0]     i_gray,
  output logic                 o_step_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     r_prev_gray;
  logic                 r_prev_vld;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [5:0]           w_dist;

  assign w_dist     = popcount(MAX_W'(i_gray ^ r_prev_gray));
  // A clear landing with a word resets the history, so that word is never judged.
  assign o_step_err = i_chk && r_prev_vld && !i_clr && (w_dist > 6'd1);
  assign o_err_cnt  = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_gray <= '0;
      r_prev_vld  <= 1'b0;
    end else if (i_chk) begin
      r_prev_gray <= i_gray;
      r_prev_vld  <= 1'b1;
    end else if (i_clr) begin
      r_prev_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (i_clr) begin
      r_err_cnt <= '0;
    end else if (o_step_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gray_code_converter_pipe.sv
// Registered Gray<->binary converter, mode chosen per word, with G2B step checking; 1-cycle latency.
// Single output register; in_ready = !out_valid || out_ready, so full throughput under steady ready.
module gray_code_converter_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_mode,
  output logic                 out_step_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_mode;
  logic             r_out_err;
  logic             w_acc;
  logic             w_g2b;
  logic [WIDTH-1:0] w_conv;
  logic             w_step_err;

  assign in_ready = !r_out_vld || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_g2b    = (in_mode == MODE_G2B);

  always_comb begin
    w_conv = '0;
    if (w_g2b) begin
      w_conv = WIDTH'(gray2bin(MAX_W'(in_data)));
    end else begin
      w_conv = WIDTH'(bin2gray(MAX_W'(in_data)));
    end
  end

  gray_step_checker #(
    .WIDTH    (WIDTH),
    .ERR_CNT_W(ERR_CNT_W)
  ) u_step_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_chk     (w_acc && w_g2b),
    .i_clr     (err_clr),
    .i_gray    (in_data),
    .o_step_err(w_step_err),
    .o_err_cnt (err_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_mode <= 1'b0;
      r_out_err  <= 1'b0;
    end else if (w_acc) begin
      r_out_vld  <= 1'b1;
      r_out_data <= w_conv;
      r_out_mode <= in_mode;
      r_out_err  <= w_step_err;
    end else if (out_ready) begin
      r_out_vld  <= 1'b0;
    end
  end

  assign out_valid    = r_out_vld;
  assign out_data     = r_out_data;
  assign out_mode     = r_out_mode;
  assign out_step_err = r_out_err;

endmodule
